pingpong_wr_ctrl: RTL
=====================

# pingpong_wr_ctrl

Write-side controller for the ping-pong frame buffer. It accepts a valid/ready word stream and writes each frame into the current write buffer, generating the buffer's `wr_addr`, `wr_data`, `wr_en` and `switch_buf` signals. It hands each completed frame to the read side with a `frame_valid`/`rd_done` handshake, and stalls the stream when both buffers are occupied.

## Interface
- `WIDTH`, default 8: data word width; must match the buffer `WIDTH`.
- `DEPTH`, default 16: words per buffer, which is the maximum frame length. `ADDR_WIDTH = $clog2(DEPTH)`.
- `clk`  in  1: clock. All logic is on the rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `s_data`  in  WIDTH: stream data.
- `s_valid`  in  1: stream word valid.
- `s_last`  in  1: the current word ends the frame; qualified by `s_valid && s_ready`.
- `s_ready`  out  1: controller accepts a word this cycle.
- `wr_addr`  out  ADDR_WIDTH: buffer write address.
- `wr_data`  out  WIDTH: buffer write data.
- `wr_en`  out  1: buffer write strobe.
- `switch_buf`  out  1: one-cycle pulse that toggles the buffer's write/read roles.
- `frame_valid`  out  1: the read buffer holds an unconsumed frame.
- `frame_len`  out  ADDR_WIDTH+1: word count of the frame in the read buffer, range 1..DEPTH. Meaningful while `frame_valid` is high.
- `rd_done`  in  1: one-cycle pulse from the reader; the frame in the read buffer is consumed.

## Operation
- **Handshake.** A word is accepted when `s_valid && s_ready` is high at a rising edge.
- **`s_ready`** is combinational and equals `state == FILL`.
- **Word counter.** `cnt` (ADDR_WIDTH bits) is the address of the next word.
- **Frame completion.** A frame completes on the accepted word where `cnt == DEPTH-1` or `s_last == 1`. `s_last` on a word with `cnt == DEPTH-1` is one completion, not two.
- **Reader busy.** `busy = frame_valid || switch_buf`.
- **Reader free.** `free = !busy || (frame_valid && rd_done)`.
- **States:**
  - FILL, the reset state. `s_ready = 1`.
  - WAIT_RD. `s_ready = 0`; a completed frame sits in the write buffer waiting for the read side to release.
- **FILL, accepted word, frame not complete:** `cnt <= cnt+1`.
- **FILL, frame complete and `free`:**
  - `switch_buf <= 1`, `frame_len <= cnt+1`, `cnt <= 0`.
  - Stay in FILL.
- **FILL, frame complete and not `free`:**
  - `pend_len <= cnt+1`, `cnt <= 0`.
  - Go to WAIT_RD.
- **WAIT_RD, `rd_done` with `frame_valid`:**
  - `switch_buf <= 1`, `frame_len <= pend_len`.
  - Go to FILL.
- **`frame_valid` update.** Evaluated in priority order:
  1. Set to 1 in the cycle after a `switch_buf` pulse.
  2. Otherwise cleared by `rd_done`.
  3. Otherwise held.
- **Handover gap.** `frame_valid` therefore drops for exactly one cycle at every handover.
- **Ignored `rd_done`.** `rd_done` while `frame_valid == 0` has no effect, including during the `switch_buf` cycle.
- **`switch_buf` width.** Never high for two consecutive cycles.
- **Arithmetic.** `cnt+1` and `pend_len` are computed at ADDR_WIDTH+1 bits, so DEPTH fits. `cnt` never wraps past DEPTH-1; completion resets it to 0.

## Timing
- **Reset values:**
  - `wr_en = 0`, `wr_addr = 0`, `wr_data = 0`.
  - `switch_buf = 0`, `frame_valid = 0`, `frame_len = 0`.
  - State FILL, so `s_ready = 1`.
  - `cnt = 0`, `pend_len = 0`.
- **Write latency.** A word accepted at edge t appears on registered `wr_en = 1`, `wr_addr = cnt`, `wr_data = s_data` during cycle t..t+1. Latency is 1 cycle. `wr_en = 0` in cycles with no accept.
- **Last-word ordering.** On the immediate-switch path, `switch_buf` is high in the same cycle as the frame's last `wr_en`. The last word lands in the old buffer, and the roles toggle at the end of that cycle.
- **Next frame.** A word accepted at the edge ending the `switch_buf` cycle writes address 0 of the new buffer. Throughput is 1 word/clk with no bubble when the reader is free.
- **Stall path.** `switch_buf` pulses 1 cycle after `rd_done` is sampled. `s_ready` rises in that same cycle.
- **Reset mid-frame.** The partial frame is discarded, `cnt = 0`, and all outputs return to their reset values. The buffer's own `wr_buf` is reset by the same `rst_n`.

## Test plan
- **Single full frame:** 16 words 0x00..0x0F, back-to-back, reader idle.
  - Required: `wr_addr` 0..15 with matching data.
  - `switch_buf` high with the addr-15 write.
  - `frame_valid = 1`, `frame_len = 16` the next cycle.
- **Short frame:** 5 words with `s_last` on the 5th.
  - Required: `switch_buf` with the addr-4 write, `frame_len = 5`.
  - The next word is written at addr 0.
- **Back-pressure:** two full frames streamed, no `rd_done`.
  - Required: `s_ready = 0` after the second frame's 16th accept; state WAIT_RD.
  - `rd_done` pulse → `frame_valid` low for 1 cycle, `switch_buf` pulse, `frame_len = 16`, `s_ready = 1`.
- **Simultaneous completion and `rd_done`:** `rd_done` in the cycle the last word of frame 2 is accepted.
  - Required: immediate `switch_buf`, no entry to WAIT_RD, zero stall cycles.
- **Spurious `rd_done`:** `rd_done` pulsed with `frame_valid = 0`.
  - Required: no output change.
- **Reset mid-frame:** `rst_n` low after 7 words.
  - Required: all outputs at reset values immediately.
  - After release, the first word is written at addr 0 and `frame_valid = 0`.

Source files
------------

// File: rtl/pingpong_wr_if.sv
// Stream, buffer-write and reader-handshake signals of the ping-pong write controller.
interface pingpong_wr_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);

  logic [WIDTH-1:0]      s_data;
  logic                  s_valid;
  logic                  s_last;
  logic                  s_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [WIDTH-1:0]      wr_data;
  logic                  wr_en;
  logic                  switch_buf;
  logic                  frame_valid;
  logic [ADDR_WIDTH:0]   frame_len;
  logic                  rd_done;

  // Controller side
  modport slave (
    input  s_data, s_valid, s_last, rd_done,
    output s_ready, wr_addr, wr_data, wr_en, switch_buf, frame_valid, frame_len
  );

  // Stream source / reader side
  modport master (
    output s_data, s_valid, s_last, rd_done,
    input  s_ready, wr_addr, wr_data, wr_en, switch_buf, frame_valid, frame_len
  );
endinterface

// File: rtl/pingpong_wr_ctrl.sv
// Write-side controller of the ping-pong frame buffer: writes stream words into
// the current write buffer, toggles buffer roles at frame completion and stalls
// the stream while both buffers hold frames.
module pingpong_wr_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  pingpong_wr_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic {FILL, WAIT_RD} state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  cnt_q, cnt_d;
  logic [AW:0]    pend_len_q, pend_len_d;
  logic [AW:0]    frame_len_q, frame_len_d;
  logic           switch_q, switch_d;
  logic           frame_valid_q, frame_valid_d;
  logic           wr_en_q, wr_en_d;
  logic [AW-1:0]  wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0] wr_data_q, wr_data_d;

  logic           accept;
  logic           complete;
  logic           busy;
  logic           free;
  logic [AW:0]    cnt_p1;

  assign bus.s_ready = (state_q == FILL);
  assign accept      = bus.s_valid && bus.s_ready;
  // A word with s_last at the final address is a single completion.
  assign complete    = accept && ((cnt_q == LAST_ADDR) || bus.s_last);
  assign busy        = frame_valid_q || switch_q;
  assign free        = !busy || (frame_valid_q && bus.rd_done);
  // One bit wider than the address so a full DEPTH-word frame length fits.
  assign cnt_p1      = {1'b0, cnt_q} + (AW + 1)'(1);

  // Next-state logic: word counter, buffer handover and stall decisions.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_len_d  = pend_len_q;
    frame_len_d = frame_len_q;
    switch_d    = 1'b0;
    wr_en_d     = accept;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;

    if (accept) begin
      wr_addr_d = cnt_q;
      wr_data_d = bus.s_data;
    end

    case (state_q)
      FILL: begin
        if (complete) begin
          cnt_d = '0;
          if (free) begin
            // Last word lands in the old buffer in the same cycle as the toggle.
            switch_d    = 1'b1;
            frame_len_d = cnt_p1;
          end else begin
            pend_len_d = cnt_p1;
            state_d    = WAIT_RD;
          end
        end else if (accept) begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      WAIT_RD: begin
        if (bus.rd_done && frame_valid_q) begin
          switch_d    = 1'b1;
          frame_len_d = pend_len_q;
          state_d     = FILL;
        end
      end
      default: state_d = FILL;
    endcase

    // A fresh frame is visible the cycle after the toggle; rd_done only
    // matters while a frame is actually held.
    if (switch_q) begin
      frame_valid_d = 1'b1;
    end else if (bus.rd_done) begin
      frame_valid_d = 1'b0;
    end else begin
      frame_valid_d = frame_valid_q;
    end
  end

  // State and output registers; reset discards any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FILL;
      cnt_q         <= '0;
      pend_len_q    <= '0;
      frame_len_q   <= '0;
      switch_q      <= 1'b0;
      frame_valid_q <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pend_len_q    <= pend_len_d;
      frame_len_q   <= frame_len_d;
      switch_q      <= switch_d;
      frame_valid_q <= frame_valid_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
    end
  end

  assign bus.wr_en       = wr_en_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.switch_buf  = switch_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_len   = frame_len_q;
endmodule
